xor_parity_stream: RTL and testbench

Streaming, parametrised successor to the single-bit XOR gate. It folds a framed stream of WIDTH-bit words into a column-parity word (bitwise XOR of all beats) plus a reduction parity bit. It works in two modes: generate, or check (the last beat is the check word and a syndrome/error is produced). It sits between a word source and a sink, with valid/ready on both sides.

---
 rtl/xor_parity_pkg.sv | 12 +
 rtl/xor_reduce.sv | 11 +
 rtl/xor_parity_stream.sv | 105 ++++++++++
 tb/tb_xor_parity_stream.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_parity_pkg.sv
// Shared types and constants for the streaming XOR parity block.
package xor_parity_pkg;

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/xor_reduce.sv
// Combinational reduction XOR of a WIDTH-bit vector.
module xor_reduce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] vec,
  output logic             par
);

  assign par = ^vec;

endmodule

// File: rtl/xor_parity_stream.sv
// Folds a framed word stream into a column-XOR word plus parity bit; in check
// mode the final beat is the check word and the fold is the syndrome.
module xor_parity_stream
  import xor_parity_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             odd,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_col,
  output logic             out_par,
  output logic             out_err,
  output logic [LEN_W-1:0] out_len
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [LEN_W-1:0] cnt;
  logic             mode_l;
  logic             odd_l;

  logic             accept;
  logic             first;
  logic             mode_eff;
  logic             odd_eff;
  logic [WIDTH-1:0] col_nxt;
  logic [LEN_W-1:0] len_nxt;
  logic             col_par;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (v == {LEN_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign in_ready  = (state == S_ACC);
  assign out_valid = (state == S_OUT);
  assign accept    = in_valid & in_ready;

  // cnt never wraps, so zero identifies the first beat of a frame; the live
  // mode/odd inputs apply to that beat, the latched copies to the rest.
  assign first    = (cnt == '0);
  assign mode_eff = first ? mode : mode_l;
  assign odd_eff  = first ? odd  : odd_l;
  assign col_nxt  = acc ^ in_data;
  assign len_nxt  = sat_inc(cnt);

  xor_reduce #(.WIDTH(WIDTH)) u_reduce (
    .vec (col_nxt),
    .par (col_par)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_ACC:   if (in_valid && in_last) state_nxt = S_OUT;
      S_OUT:   if (out_ready)           state_nxt = S_ACC;
      default: state_nxt = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      mode_l  <= MODE_GEN;
      odd_l   <= 1'b0;
      out_col <= '0;
      out_par <= 1'b0;
      out_err <= 1'b0;
      out_len <= '0;
    end else if (accept) begin
      if (first) begin
        mode_l <= mode;
        odd_l  <= odd;
      end
      if (in_last) begin
        out_col <= col_nxt;
        out_len <= len_nxt;
        out_par <= col_par ^ odd_eff;
        out_err <= (mode_eff == MODE_CHK) && (|col_nxt);
      end else begin
        acc <= col_nxt;
        cnt <= len_nxt;
      end
    end else if (out_valid && out_ready) begin
      acc <= '0;
      cnt <= '0;
    end
  end

endmodule

// File: tb/tb_xor_parity_stream.sv
// Randomised scoreboard bench for xor_parity_stream with a frame-level model.
module tb_xor_parity_stream;

  localparam int WIDTH   = 8;
  localparam int LEN_W   = 4;
  localparam int LEN_MAX = (1 << LEN_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             mode = 1'b0;
  logic             odd = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_col;
  logic             out_par;
  logic             out_err;
  logic [LEN_W-1:0] out_len;

  xor_parity_stream #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .odd       (odd),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_par   (out_par),
    .out_err   (out_err),
    .out_len   (out_len)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] col;
    logic             par;
    logic             err;
    logic [LEN_W-1:0] len;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] beats[$];
  int               n_checks = 0;
  int               n_fail = 0;
  int               bp_mode = 0;   // 0: always ready, 1: random, 2: stall hold_left cycles
  int               hold_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Frame-level reference: XOR of every word, parity by counting ones.
  function automatic exp_t model(input bit m, input bit o);
    logic [WIDTH-1:0] x;
    int               ones;
    exp_t             e;
    x    = '0;
    ones = 0;
    foreach (beats[i]) x = x ^ beats[i];
    for (int b = 0; b < WIDTH; b++) if (x[b]) ones++;
    e.col = x;
    e.par = ((ones % 2) == 1) ^ o;
    e.err = m && (x != 0);
    e.len = LEN_W'((beats.size() > LEN_MAX) ? LEN_MAX : beats.size());
    return e;
  endfunction

  // Called at a negedge with the beat presented; returns at the negedge after acceptance.
  task automatic wait_accept();
    int t = 0;
    while (!in_ready) begin
      @(negedge clk);
      t++;
      if (t > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "in_ready timeout");
      end
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input bit m, input bit o, input bit toggle_mid);
    exp_q.push_back(model(m, o));
    for (int i = 0; i < beats.size(); i++) begin
      mode     = (toggle_mid && i == 1) ? ~m : m;
      odd      = (toggle_mid && i == 1) ? ~o : o;
      in_valid = 1'b1;
      in_data  = beats[i];
      in_last  = (i == beats.size() - 1);
      wait_accept();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom_range(0, 255);
    check("latency_out_valid", out_valid, 1);
    check("in_ready_low_after_last", in_ready, 0);
  endtask

  initial begin : monitor
    exp_t e;
    exp_t held;
    bit   stalled;
    bit   hs_prev;
    stalled = 0;
    hs_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled   = 0;
        hs_prev   = 0;
        out_ready = 1'b0;
        continue;
      end
      if (hs_prev) begin
        check("in_ready_after_release", in_ready, 1);
        check("out_valid_dropped", out_valid, 0);
      end
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid && hold_left > 0) begin
            out_ready = 1'b0;
            hold_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      hs_prev = 0;
      if (out_valid) begin
        check("in_ready_low_while_valid", in_ready, 0);
        if (stalled) begin
          check("stable_col", out_col, held.col);
          check("stable_par", out_par, held.par);
          check("stable_err", out_err, held.err);
          check("stable_len", out_len, held.len);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got col %0h len %0d, required no result", out_col, out_len);
          end else begin
            e = exp_q.pop_front();
            check("out_col", out_col, e.col);
            check("out_par", out_par, e.par);
            check("out_err", out_err, e.err);
            check("out_len", out_len, e.len);
          end
          stalled = 0;
          hs_prev = 1;
        end else begin
          stalled  = 1;
          held.col = out_col;
          held.par = out_par;
          held.err = out_err;
          held.len = out_len;
        end
      end else begin
        stalled = 0;
      end
    end
  end

  initial begin : stimulus
    int t;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_col", out_col, 0);
    check("rst_out_par", out_par, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_len", out_len, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    beats = '{8'h0F, 8'hF0, 8'h01};
    send_frame(1'b0, 1'b0, 1'b0);

    beats = '{8'h12, 8'h34, 8'h26};
    send_frame(1'b1, 1'b0, 1'b0);
    beats = '{8'h12, 8'h34, 8'h27};
    send_frame(1'b1, 1'b0, 1'b0);

    // Stall the result while the next frame's first beat is already offered.
    bp_mode   = 2;
    hold_left = 5;
    beats = '{8'h3C, 8'h81, 8'h7E};
    send_frame(1'b0, 1'b1, 1'b0);
    beats = '{8'h55, 8'hAA};
    send_frame(1'b0, 1'b0, 1'b0);
    bp_mode = 0;

    beats = '{8'hA5};
    send_frame(1'b0, 1'b1, 1'b0);
    beats = '{8'h9C, 8'h3D, 8'h9C};
    send_frame(1'b1, 1'b0, 1'b1);
    beats = '{8'h11, 8'h22, 8'h40};
    send_frame(1'b0, 1'b1, 1'b1);

    // Partial frame discarded by reset.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
      in_last  = 1'b0;
      wait_accept();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_out_valid", out_valid, 0);
    beats = '{8'h01};
    send_frame(1'b0, 1'b0, 1'b0);

    beats.delete();
    for (int i = 0; i < 20; i++) beats.push_back(8'h00);
    send_frame(1'b0, 1'b0, 1'b0);

    bp_mode = 1;
    for (int f = 0; f < 30; f++) begin
      beats.delete();
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) beats.push_back(WIDTH'($urandom_range(0, 255)));
      if (f % 5 == 0) beats.push_back(8'h00);
      send_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
